// File: rtl/rvfi_check_sched.sv
// rvfi_check_sched -- phase scheduler for a formal checker instance.
//
// Drives the reset, trig and check inputs of a checker. It runs a saturating
// cycle counter and walks the sequence RST -> WAIT -> ARMED -> TRIGD -> DONE,
// or ends in TOUT if the sequence is abandoned.
//
// Optional feature: define RISCV_FORMAL_SCHED_RETIRE_ALIGN_EN to fire trig
// only on a cycle with a retirement on rvfi_valid. In that build a window
// counter bounds the time spent in ARMED. Without the macro, trig fires
// unconditionally at cycle == TRIG_CYCLE and rvfi_valid is ignored.
//
// Ports:
//   clock      in   sole clock, rising edge
//   reset      in   synchronous active-high reset
//   rvfi_valid in   [NRET] per-channel retire strobes
//   cycle      out  [8] current cycle number (reads 0 during reset)
//   chk_reset  out  reset for the checker
//   trig       out  one-cycle trigger pulse
//   check      out  one-cycle check pulse, CHECK_DELAY cycles after trig
//   done       out  sticky, check has fired
//   timeout    out  sticky, sequence abandoned
//
// Formal properties are in rvfi_check_sched_props. That module is bound in
// only when YOSYS is defined.

module rvfi_check_sched #(
  parameter int NRET         = 1,
  parameter int RESET_CYCLES = 1,
  parameter int TRIG_CYCLE   = 10,
  parameter int TRIG_WINDOW  = 8,
  parameter int CHECK_DELAY  = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NRET-1:0] rvfi_valid,
  output logic [7:0]      cycle,
  output logic            chk_reset,
  output logic            trig,
  output logic            check,
  output logic            done,
  output logic            timeout
);

  // Elaboration-time parameter sanity checks.
  if (TRIG_CYCLE + TRIG_WINDOW + CHECK_DELAY >= 255) begin : g_bad_sum
    $error("rvfi_check_sched: TRIG_CYCLE + TRIG_WINDOW + CHECK_DELAY must be < 255");
  end
  if (TRIG_CYCLE < RESET_CYCLES) begin : g_bad_trig
    $error("rvfi_check_sched: TRIG_CYCLE must be >= RESET_CYCLES");
  end
  if (TRIG_WINDOW < 1 || CHECK_DELAY < 1) begin : g_bad_min
    $error("rvfi_check_sched: TRIG_WINDOW and CHECK_DELAY must be >= 1");
  end

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ARMED = 3'd2,
    ST_TRIGD = 3'd3,
    ST_DONE  = 3'd4,
    ST_TOUT  = 3'd5
  } state_t;

  localparam logic [7:0] RESET_C8  = 8'(RESET_CYCLES);
  localparam logic [8:0] TRIG_C9   = 9'(TRIG_CYCLE);
  localparam logic [7:0] DCNT_LOAD = 8'(CHECK_DELAY - 1);

  state_t     state_r;
  state_t     next_s;
  logic [7:0] cycle_r;
  logic [7:0] dcnt_r;
  logic       done_r;
  logic       timeout_r;
  logic       trig_s;
  logic       check_s;
  logic       fire_s;
  logic [8:0] cycle_next_s;

`ifdef RISCV_FORMAL_SCHED_RETIRE_ALIGN_EN
  localparam logic [7:0] WIN_LAST = 8'(TRIG_WINDOW - 1);
  logic [7:0] wcnt_r;

  assign fire_s = |rvfi_valid;

  // Window counter: counts ARMED cycles that end without a trigger.
  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt_r <= 8'd0;
    end else if (state_r == ST_ARMED && !trig_s) begin
      wcnt_r <= wcnt_r + 8'd1;
    end else begin
      wcnt_r <= wcnt_r;
    end
  end
`else
  logic unused_valid_s;
  assign unused_valid_s = ^rvfi_valid;
  assign fire_s         = 1'b1;
`endif

  // Saturating cycle counter. It loads 1 on reset, so the reset cycle itself is cycle 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_r <= 8'd1;
    end else if (cycle_r != 8'd255) begin
      cycle_r <= cycle_r + 8'd1;
    end else begin
      cycle_r <= cycle_r;
    end
  end

  // Visible cycle number and checker reset.
  always_comb begin
    if (reset) begin
      cycle = 8'd0;
    end else begin
      cycle = cycle_r;
    end
    chk_reset    = reset | (cycle < RESET_C8);
    cycle_next_s = {1'b0, cycle} + 9'd1;
  end

  // Next-state logic and the trig/check pulses.
  always_comb begin
    next_s  = state_r;
    trig_s  = 1'b0;
    check_s = 1'b0;
    case (state_r)
      ST_RST: begin
        // Jump straight to ARMED when the trigger cycle follows the
        // checker-reset phase with no gap. This covers TRIG_CYCLE == RESET_CYCLES.
        if (cycle_next_s >= TRIG_C9) begin
          next_s = ST_ARMED;
        end else if (!chk_reset) begin
          next_s = ST_WAIT;
        end else begin
          next_s = ST_RST;
        end
      end
      ST_WAIT: begin
        if (cycle_next_s >= TRIG_C9) begin
          next_s = ST_ARMED;
        end else begin
          next_s = ST_WAIT;
        end
      end
      ST_ARMED: begin
        if (fire_s) begin
          trig_s = 1'b1;
          next_s = ST_TRIGD;
        end else begin
`ifdef RISCV_FORMAL_SCHED_RETIRE_ALIGN_EN
          if (wcnt_r == WIN_LAST) begin
            next_s = ST_TOUT;
          end else begin
            next_s = ST_ARMED;
          end
`else
          next_s = ST_ARMED;
`endif
        end
      end
      ST_TRIGD: begin
        if (dcnt_r == 8'd0) begin
          check_s = 1'b1;
          next_s  = ST_DONE;
        end else begin
          next_s = ST_TRIGD;
        end
      end
      ST_DONE: next_s = ST_DONE;
      ST_TOUT: next_s = ST_TOUT;
      default: next_s = ST_RST;
    endcase

    // A saturated counter means the sequence can no longer finish.
    if (cycle_r == 8'd255 && state_r != ST_DONE && state_r != ST_TOUT) begin
      next_s = ST_TOUT;
    end else begin
      next_s = next_s;
    end

    // Reset aborts immediately and suppresses both pulses in the reset cycle.
    if (reset) begin
      next_s  = ST_RST;
      trig_s  = 1'b0;
      check_s = 1'b0;
    end else begin
      trig_s  = trig_s;
      check_s = check_s;
    end
  end

  // State register and the sticky status flags. The flags are registered from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_RST;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= next_s;
      done_r    <= (next_s == ST_DONE);
      timeout_r <= (next_s == ST_TOUT);
    end
  end

  // Delay counter between trig and check.
  always_ff @(posedge clock) begin
    if (reset) begin
      dcnt_r <= 8'd0;
    end else if (trig_s) begin
      dcnt_r <= DCNT_LOAD;
    end else if (state_r == ST_TRIGD && dcnt_r != 8'd0) begin
      dcnt_r <= dcnt_r - 8'd1;
    end else begin
      dcnt_r <= dcnt_r;
    end
  end

  assign trig    = trig_s;
  assign check   = check_s;
  assign done    = done_r;
  assign timeout = timeout_r;

`ifdef YOSYS
  rvfi_check_sched_props #(
    .CHECK_DELAY(CHECK_DELAY)
  ) u_props (
    .clock   (clock),
    .reset   (reset),
    .cycle   (cycle),
    .trig    (trig),
    .check   (check),
    .done    (done),
    .timeout (timeout)
  );
`endif

endmodule

`ifdef YOSYS
// Formal properties of the scheduler outputs.
module rvfi_check_sched_props #(
  parameter int CHECK_DELAY = 4
) (
  input logic       clock,
  input logic       reset,
  input logic [7:0] cycle,
  input logic       trig,
  input logic       check,
  input logic       done,
  input logic       timeout
);

  logic                 trig_seen_r;
  logic [CHECK_DELAY:0] hist_r;

  // History of trig pulses. hist_r[k-1] holds the value of trig k cycles ago.
  always_ff @(posedge clock) begin
    if (reset) begin
      trig_seen_r <= 1'b0;
      hist_r      <= '0;
    end else begin
      trig_seen_r <= trig_seen_r | trig;
      hist_r      <= {hist_r[CHECK_DELAY-1:0], trig};
    end
  end

  // Property checks, evaluated outside of reset.
  always @(posedge clock) begin
    if (!reset) begin
      assert (!(trig && trig_seen_r));
      assert (!check || hist_r[CHECK_DELAY-1]);
      assert (!(done && timeout));
      assert (!(cycle == 8'd255 && !done && !timeout));
    end
  end

endmodule
`endif

// File: tb/tb_rvfi_check_sched.sv
module tb_rvfi_check_sched;

  logic       clock = 1'b0;
  logic       reset_a, reset_b;
  logic [0:0] valid_a, valid_b;
  logic [7:0] cycle_a, cycle_b;
  logic       chk_a, trig_a, check_a, done_a, tout_a;
  logic       chk_b, trig_b, check_b, done_b, tout_b;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  rvfi_check_sched #(
    .NRET(1), .RESET_CYCLES(1), .TRIG_CYCLE(10), .TRIG_WINDOW(8), .CHECK_DELAY(4)
  ) dut_a (
    .clock(clock), .reset(reset_a), .rvfi_valid(valid_a), .cycle(cycle_a),
    .chk_reset(chk_a), .trig(trig_a), .check(check_a), .done(done_a), .timeout(tout_a)
  );

  rvfi_check_sched #(
    .NRET(1), .RESET_CYCLES(3), .TRIG_CYCLE(3), .TRIG_WINDOW(8), .CHECK_DELAY(4)
  ) dut_b (
    .clock(clock), .reset(reset_b), .rvfi_valid(valid_b), .cycle(cycle_b),
    .chk_reset(chk_b), .trig(trig_b), .check(check_b), .done(done_b), .timeout(tout_b)
  );

  // Inputs change on the falling edge. Outputs are sampled 1 time unit later.
  task automatic drive_a(input logic r, input logic v);
    @(negedge clock);
    reset_a = r;
    valid_a = v;
    #1;
  endtask

  task automatic drive_b(input logic r, input logic v);
    @(negedge clock);
    reset_b = r;
    valid_b = v;
    #1;
  endtask

  task automatic test_reset();
    drive_a(1'b1, 1'b0);
    compared++;
    if ({cycle_a, chk_a, trig_a, check_a} !== {8'd0, 1'b1, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_cycle0 got=%b want=%b", {cycle_a, chk_a, trig_a, check_a}, {8'd0, 1'b1, 1'b0, 1'b0});
    end
    drive_a(1'b0, 1'b1);
    compared++;
    if ({cycle_a, chk_a, trig_a, check_a, done_a, tout_a} !== {8'd1, 5'b00000}) begin
      mismatched++;
      $display("FAIL reset_cycle1 got=%b want=%b", {cycle_a, chk_a, trig_a, check_a, done_a, tout_a}, {8'd1, 5'b00000});
    end
  endtask

  // Retire held high, so the trigger lands on TRIG_CYCLE in either build.
  task automatic test_basic();
    logic [12:0] got, exp, mask;
    for (int c = 0; c <= 20; c++) begin
      drive_a(c == 0, 1'b1);
      exp  = {8'(c), c < 1, c == 10, c == 14, c >= 15, 1'b0};
      mask = (c == 0) ? 13'h1FFC : 13'h1FFF;
      got  = {cycle_a, chk_a, trig_a, check_a, done_a, tout_a};
      compared++;
      if ((got & mask) !== (exp & mask)) begin
        mismatched++;
        $display("FAIL basic c=%0d got=%b want=%b", c, got & mask, exp & mask);
      end
    end
  endtask

  // Reset at cycle 12 aborts before the check, and the next epoch restarts.
  task automatic test_reset_mid();
    logic [12:0] got, exp, mask;
    int c;
    for (int s = 0; s <= 28; s++) begin
      c = (s < 12) ? s : s - 12;
      drive_a(s == 0 || s == 12, 1'b1);
      exp  = {8'(c), c < 1, c == 10, c == 14, c >= 15, 1'b0};
      mask = (s == 0) ? 13'h1FFC : 13'h1FFF;
      got  = {cycle_a, chk_a, trig_a, check_a, done_a, tout_a};
      compared++;
      if ((got & mask) !== (exp & mask)) begin
        mismatched++;
        $display("FAIL reset_mid s=%0d got=%b want=%b", s, got & mask, exp & mask);
      end
    end
  endtask

  // TRIG_CYCLE == RESET_CYCLES == 3, with no WAIT cycle between them.
  task automatic test_short();
    logic [12:0] got, exp, mask;
    for (int c = 0; c <= 10; c++) begin
      drive_b(c == 0, 1'b1);
      exp  = {8'(c), c < 3, c == 3, c == 7, c >= 8, 1'b0};
      mask = (c == 0) ? 13'h1FFC : 13'h1FFF;
      got  = {cycle_b, chk_b, trig_b, check_b, done_b, tout_b};
      compared++;
      if ((got & mask) !== (exp & mask)) begin
        mismatched++;
        $display("FAIL short c=%0d got=%b want=%b", c, got & mask, exp & mask);
      end
    end
  endtask

  // Run well past done. The cycle saturates at 255 while the state stays DONE.
  task automatic test_saturate();
    logic [12:0] got, exp, mask;
    for (int c = 0; c <= 320; c++) begin
      drive_a(c == 0, 1'b1);
      exp  = {(c > 255) ? 8'd255 : 8'(c), c < 1, c == 10, c == 14, c >= 15, 1'b0};
      mask = (c == 0) ? 13'h1FFC : 13'h1FFF;
      got  = {cycle_a, chk_a, trig_a, check_a, done_a, tout_a};
      compared++;
      if ((got & mask) !== (exp & mask)) begin
        mismatched++;
        $display("FAIL saturate c=%0d got=%b want=%b", c, got & mask, exp & mask);
      end
    end
  endtask

`ifdef RISCV_FORMAL_SCHED_RETIRE_ALIGN_EN
  // The retire at cycle 5 is ignored. The trigger aligns to the retire at cycle 13.
  task automatic test_retire();
    logic [12:0] got, exp, mask;
    for (int c = 0; c <= 22; c++) begin
      drive_a(c == 0, (c == 5) || (c == 13));
      exp  = {8'(c), c < 1, c == 13, c == 17, c >= 18, 1'b0};
      mask = (c == 0) ? 13'h1FFC : 13'h1FFF;
      got  = {cycle_a, chk_a, trig_a, check_a, done_a, tout_a};
      compared++;
      if ((got & mask) !== (exp & mask)) begin
        mismatched++;
        $display("FAIL retire c=%0d got=%b want=%b", c, got & mask, exp & mask);
      end
    end
  endtask

  // No retire at all, so the window expires and timeout is set from cycle 18.
  task automatic test_window();
    logic [12:0] got, exp, mask;
    for (int c = 0; c <= 30; c++) begin
      drive_a(c == 0, 1'b0);
      exp  = {8'(c), c < 1, 1'b0, 1'b0, 1'b0, c >= 18};
      mask = (c == 0) ? 13'h1FFC : 13'h1FFF;
      got  = {cycle_a, chk_a, trig_a, check_a, done_a, tout_a};
      compared++;
      if ((got & mask) !== (exp & mask)) begin
        mismatched++;
        $display("FAIL window c=%0d got=%b want=%b", c, got & mask, exp & mask);
      end
    end
  endtask
`else
  // rvfi_valid is held low and has no effect. The trigger still fires at cycle 10.
  task automatic test_ignore_valid();
    logic [12:0] got, exp, mask;
    for (int c = 0; c <= 24; c++) begin
      drive_a(c == 0, 1'b0);
      exp  = {8'(c), c < 1, c == 10, c == 14, c >= 15, 1'b0};
      mask = (c == 0) ? 13'h1FFC : 13'h1FFF;
      got  = {cycle_a, chk_a, trig_a, check_a, done_a, tout_a};
      compared++;
      if ((got & mask) !== (exp & mask)) begin
        mismatched++;
        $display("FAIL ignore_valid c=%0d got=%b want=%b", c, got & mask, exp & mask);
      end
    end
  endtask
`endif

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    test_reset();
    test_basic();
    test_reset_mid();
    test_short();
`ifdef RISCV_FORMAL_SCHED_RETIRE_ALIGN_EN
    test_retire();
    test_window();
`else
    test_ignore_valid();
`endif
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
